// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registered issue stage in front of the LC-3b ALU.
// Decode hands over aluop/SR1/SR2/IR, and the stage forms the B operand from
// SR2 or an IR immediate. It presents a stable aluop/A/B to the ALU.
// Storage is a 2-entry skid buffer: an output register (OR) and a skid
// register (SR). in_ready is simply ~SR.valid and comes straight from a
// flop, so there is no combinational path from out_ready to in_ready.
// Optional feature: define ALU_ISSUE_STALL_CNT_EN to add the saturating
// stall_cnt output. It counts the cycles where the output is valid but not
// consumed.

package lc3b_types;
    typedef enum logic [2:0] {
        alu_add  = 3'd0,
        alu_and  = 3'd1,
        alu_not  = 3'd2,
        alu_pass = 3'd3,
        alu_sll  = 3'd4,
        alu_srl  = 3'd5,
        alu_sra  = 3'd6
    } lc3b_aluop;
endpackage

module alu_issue_stage
    import lc3b_types::*;
#(
    parameter int DATA_W      = 16,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  lc3b_aluop              in_aluop,
    input  logic [DATA_W-1:0]      in_sr1,
    input  logic [DATA_W-1:0]      in_sr2,
    input  logic [15:0]            in_ir,
    input  logic [1:0]             in_bsel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output lc3b_aluop              out_aluop,
    output logic [DATA_W-1:0]      out_a,
`ifdef ALU_ISSUE_STALL_CNT_EN
    output logic [DATA_W-1:0]      out_b,
    output logic [STALL_CNT_W-1:0] stall_cnt
`else
    output logic [DATA_W-1:0]      out_b
`endif
);

    // Output register (OR) and skid register (SR).
    logic              or_valid_q, or_valid_d;
    lc3b_aluop         or_aluop_q, or_aluop_d;
    logic [DATA_W-1:0] or_a_q,     or_a_d;
    logic [DATA_W-1:0] or_b_q,     or_b_d;

    logic              sr_valid_q, sr_valid_d;
    lc3b_aluop         sr_aluop_q, sr_aluop_d;
    logic [DATA_W-1:0] sr_a_q,     sr_a_d;
    logic [DATA_W-1:0] sr_b_q,     sr_b_d;

    logic [DATA_W-1:0] b_formed;
    logic              accept;
    logic              xfer;
    logic              or_free;

    assign in_ready = ~sr_valid_q;
    assign accept   = in_valid & in_ready;
    assign xfer     = or_valid_q & out_ready;
    // OR can take a new value: it is empty, or it drains this cycle.
    assign or_free  = ~or_valid_q | out_ready;

    // B operand mux: a sign-extended imm5, a zero-extended shift amount, or SR2.
    always_comb begin
        b_formed = in_sr2;
        case (in_bsel)
            2'd1:    b_formed = {{(DATA_W-5){in_ir[4]}}, in_ir[4:0]};
            2'd2:    b_formed = {{(DATA_W-4){1'b0}}, in_ir[3:0]};
            default: b_formed = in_sr2;
        endcase
    end

    // Next-state for both entries. Flush wins, then the OR refill/drain, then the SR load.
    always_comb begin
        or_valid_d = or_valid_q;
        or_aluop_d = or_aluop_q;
        or_a_d     = or_a_q;
        or_b_d     = or_b_q;
        sr_valid_d = sr_valid_q;
        sr_aluop_d = sr_aluop_q;
        sr_a_d     = sr_a_q;
        sr_b_d     = sr_b_q;

        if (flush) begin
            // Payloads are left stale on purpose; only the valids matter.
            or_valid_d = 1'b0;
            sr_valid_d = 1'b0;
        end else if (or_free) begin
            if (sr_valid_q) begin
                // in_ready is low here, so no accept competes with the drain.
                or_valid_d = 1'b1;
                or_aluop_d = sr_aluop_q;
                or_a_d     = sr_a_q;
                or_b_d     = sr_b_q;
                sr_valid_d = 1'b0;
            end else if (accept) begin
                or_valid_d = 1'b1;
                or_aluop_d = in_aluop;
                or_a_d     = in_sr1;
                or_b_d     = b_formed;
            end else begin
                or_valid_d = 1'b0;
            end
        end else if (accept) begin
            sr_valid_d = 1'b1;
            sr_aluop_d = in_aluop;
            sr_a_d     = in_sr1;
            sr_b_d     = b_formed;
        end
    end

    // Storage registers. The async reset clears both valids, so in_ready returns to 1 at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_valid_q <= 1'b0;
            or_aluop_q <= alu_pass;
            or_a_q     <= '0;
            or_b_q     <= '0;
            sr_valid_q <= 1'b0;
            sr_aluop_q <= alu_pass;
            sr_a_q     <= '0;
            sr_b_q     <= '0;
        end else begin
            or_valid_q <= or_valid_d;
            or_aluop_q <= or_aluop_d;
            or_a_q     <= or_a_d;
            or_b_q     <= or_b_d;
            sr_valid_q <= sr_valid_d;
            sr_aluop_q <= sr_aluop_d;
            sr_a_q     <= sr_a_d;
            sr_b_q     <= sr_b_d;
        end
    end

    assign out_valid = or_valid_q;
    assign out_aluop = or_aluop_q;
    assign out_a     = or_a_q;
    assign out_b     = or_b_q;

`ifdef ALU_ISSUE_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [14:0]            unused_ir;

    // Count backpressured cycles and saturate at all-ones. Flush leaves the count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (or_valid_q && !out_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign unused_ir = {in_ir[15:5], 4'b0};
`else
    // Upper IR bits and the counter width have no function in this build.
    logic unused_ok;
    assign unused_ok = ^{in_ir[15:5], STALL_CNT_W[0]};
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized and directed bench for alu_issue_stage. The reference model is a
// plain depth-2 FIFO queue, and its head is what the output should present.
module tb_alu_issue_stage;
    import lc3b_types::*;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } op_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    lc3b_aluop  in_aluop = alu_add;
    logic [15:0] in_sr1 = '0;
    logic [15:0] in_sr2 = '0;
    logic [15:0] in_ir = '0;
    logic [1:0]  in_bsel = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    lc3b_aluop  out_aluop;
    logic [15:0] out_a;
    logic [15:0] out_b;
`ifdef ALU_ISSUE_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int total = 0;
    int bad = 0;
    int n_out = 0;
    int stall_exp = 0;
    op_t q[$];

    always #5 clk = ~clk;

    alu_issue_stage #(.DATA_W(16), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop),
        .in_sr1(in_sr1), .in_sr2(in_sr2), .in_ir(in_ir), .in_bsel(in_bsel),
        .out_valid(out_valid), .out_ready(out_ready), .out_aluop(out_aluop),
`ifdef ALU_ISSUE_STALL_CNT_EN
        .out_a(out_a), .out_b(out_b), .stall_cnt(stall_cnt)
`else
        .out_a(out_a), .out_b(out_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] form_b(input logic [1:0] bsel, input logic [15:0] sr2,
                                           input logic [15:0] ir);
        int imm;
        if (bsel == 2'd1) begin
            imm = int'(ir) % 32;
            if (imm > 15) imm = imm - 32;
            return 16'(imm);
        end else if (bsel == 2'd2) begin
            return 16'(int'(ir) % 16);
        end
        return sr2;
    endfunction

    task automatic compare();
        check("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
        check("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
        if (q.size() > 0) begin
            check("out_aluop", {29'b0, out_aluop}, {29'b0, q[0].op});
            check("out_a", {16'b0, out_a}, {16'b0, q[0].a});
            check("out_b", {16'b0, out_b}, {16'b0, q[0].b});
        end
`ifdef ALU_ISSUE_STALL_CNT_EN
        check("stall_cnt", {16'b0, stall_cnt}, stall_exp);
`endif
    endtask

    // One clock: check at the negedge, then advance the model at the posedge.
    task automatic cycle();
        logic acc, xfr;
        op_t  item;
        @(negedge clk);
        compare();
        acc = in_valid && (q.size() < 2);
        xfr = (q.size() > 0) && out_ready;
        item.op = in_aluop;
        item.a  = in_sr1;
        item.b  = form_b(in_bsel, in_sr2, in_ir);
        @(posedge clk);
        if (q.size() > 0 && !out_ready && stall_exp < 65535) stall_exp++;
        if (flush) begin
            q.delete();
        end else begin
            if (xfr) begin
                void'(q.pop_front());
                n_out++;
            end
            if (acc) q.push_back(item);
        end
        #1;
    endtask

    task automatic drive(input logic v, input lc3b_aluop op, input logic [15:0] s1,
                         input logic [15:0] s2, input logic [15:0] ir, input logic [1:0] bs);
        in_valid = v;
        in_aluop = op;
        in_sr1   = s1;
        in_sr2   = s2;
        in_ir    = ir;
        in_bsel  = bs;
    endtask

    task automatic drive_rand(input logic v);
        drive(v, lc3b_aluop'($urandom_range(0, 6)), 16'($urandom), 16'($urandom),
              16'($urandom), 2'($urandom_range(0, 3)));
    endtask

    initial begin
        int n0;

        // Reset held with in_valid high.
        drive_rand(1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_aluop", {29'b0, out_aluop}, {29'b0, alu_pass});
        check("rst_out_a", {16'b0, out_a}, 32'd0);
        check("rst_out_b", {16'b0, out_b}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef ALU_ISSUE_STALL_CNT_EN
        check("rst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Immediates.
        out_ready = 1'b1;
        drive(1'b1, alu_add, 16'h0005, 16'h1234, 16'h101F, 2'd1);
        cycle();
        check("imm_sext_b", {16'b0, out_b}, 32'h0000FFFF);
        check("imm_sext_a", {16'b0, out_a}, 32'h00000005);
        drive(1'b1, alu_sra, 16'h8000, 16'h5555, 16'h00A7, 2'd2);
        cycle();
        check("imm_zext_b", {16'b0, out_b}, 32'h00000007);
        drive(1'b0, alu_add, 16'h0, 16'h0, 16'h0, 2'd0);
        cycle();

        // Streaming: 8 back-to-back ops.
        n0 = n_out;
        for (int i = 0; i < 8; i++) begin
            drive_rand(1'b1);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        check("stream_count", n_out - n0, 32'd8);

        // Backpressure: X held in OR, Y in SR.
        out_ready = 1'b0;
        drive(1'b1, alu_and, 16'hAAAA, 16'h0F0F, 16'h0, 2'd0);
        cycle();
        drive(1'b1, alu_not, 16'h1357, 16'h2468, 16'h0, 2'd3);
        cycle();
        in_valid = 1'b0;
        repeat (3) cycle();
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        check("bp_hold_a", {16'b0, out_a}, 32'h0000AAAA);
        out_ready = 1'b1;
        n0 = n_out;
        repeat (3) cycle();
        check("bp_drain_count", n_out - n0, 32'd2);

        // Flush with both entries full and an input offered.
        out_ready = 1'b0;
        repeat (2) begin
            drive_rand(1'b1);
            cycle();
        end
        drive_rand(1'b1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (2) cycle();

        // Asynchronous reset in the middle of a stall.
        out_ready = 1'b0;
        repeat (2) begin
            drive_rand(1'b1);
            cycle();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", {31'b0, out_valid}, 32'd0);
        check("async_in_ready", {31'b0, in_ready}, 32'd1);
        q.delete();
        stall_exp = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            drive_rand(($urandom % 4) != 0);
            out_ready = ($urandom % 3) != 0;
            flush = ($urandom % 25) == 0;
            cycle();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
